uart_rx_frame: RTL and testbench

Serial UART receiver: the receive-side counterpart of the UART parity generator. It samples the asynchronous `rx` line and recovers start, data, optional parity and stop bits. It presents each received word with a one-cycle valid strobe, plus parity and framing error flags. It sits between the board RX pin and the byte consumer (FIFO or command decoder).

---
 rtl/uart_rx_frame.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes rx, recovers start/data/parity/stop bits and flags errors.
// Optional parity bit and check compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    rx_meta;
    logic                    rx_s;
    logic                    rx_d;
    logic                    fall;
    logic                    tick;

    // NOTE: synchronizer flops reset to the idle-high line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;
    assign tick = (baud_cnt == BAUD_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_flag;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d);
        case (PARITY_TYPE)
            2:       return ~^d;
            3:       return 1'b0;
            4:       return 1'b1;
            default: return ^d;
        endcase
    endfunction
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            baud_cnt   <= tick ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (baud_cnt == BAUD_MID) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_flag <= (rx_s != expected_parity(shift_reg));
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid stop bit lets a start edge right after it be caught.
                    if (tick) begin
                        data_out   <= shift_reg;
                        frame_err  <= ~rx_s;
                        data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_flag;
`endif
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames
// compared against a frame-level model of the line protocol.
module tb_uart_rx_frame;

    localparam int CLK_FREQ  = 2_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int B         = CLK_FREQ / BAUD_RATE;
    localparam int DW        = 8;
    localparam int PTYPE     = 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          rx;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int expected_pulses = 0;
    int width_viol = 0;
    logic dv_prev = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } word_t;
    word_t rxq[$];

    uart_rx_frame #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (DW),
        .PARITY_TYPE(PTYPE)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1) begin
            if (data_valid === 1'b1) begin
                rxq.push_back('{d: data_out, pe: parity_err, fe: frame_err});
                pulses++;
                if (dv_prev) width_viol++;
            end
            dv_prev = data_valid;
        end else begin
            dv_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_parity(input logic [DW-1:0] d);
        logic even_bit;
        even_bit = logic'($countones(d) % 2);
        case (PTYPE)
            2:       return ~even_bit;
            3:       return 1'b0;
            4:       return 1'b1;
            default: return even_bit;
        endcase
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (B) @(negedge sys_clk);
    endtask

    // Sends one frame; parity bit = model parity XOR flip. Returns expected word.
    task automatic send_frame(input logic [DW-1:0] d, input logic flip, input logic stop,
                              output word_t exp);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(model_parity(d) ^ flip);
        drive_bit(stop);
        exp.d  = d;
        exp.pe = PAR_EN ? flip : 1'b0;
        exp.fe = ~stop;
        expected_pulses++;
    endtask

    task automatic expect_word(input string tag, input word_t exp);
        int budget;
        word_t got;
        budget = 0;
        while (rxq.size() == 0 && budget < 4 * B) begin
            @(negedge sys_clk);
            budget++;
        end
        check({tag, "_arrived"}, (rxq.size() > 0), 1);
        if (rxq.size() > 0) begin
            got = rxq.pop_front();
            check({tag, "_data"}, got.d, exp.d);
            check({tag, "_perr"}, got.pe, exp.pe);
            check({tag, "_ferr"}, got.fe, exp.fe);
        end
    endtask

    initial begin
        word_t e0, e1;
        logic [DW-1:0] rd;
        logic flip, stop;
        int glitch;

        rx = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_data_out", data_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_frame_err", frame_err, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        send_frame(8'hA5, 1'b0, 1'b1, e0);
        expect_word("a5_good", e0);

        send_frame(8'hA5, 1'b1, 1'b1, e0);
        expect_word("a5_bad_parity", e0);

        send_frame(8'h81, 1'b0, 1'b1, e0);
        expect_word("x81", e0);

        // Bad stop bit, then a line held low (break) for 20 bit times.
        send_frame(8'h3C, 1'b0, 1'b0, e0);
        expect_word("x3c_frame_err", e0);
        repeat (20 * B) @(negedge sys_clk);
        check("break_no_pulse", rxq.size(), 0);
        drive_bit(1'b1);
        send_frame(8'hC3, 1'b0, 1'b1, e0);
        expect_word("after_break", e0);

        // Glitch shorter than half a bit on an idle line.
        glitch = $urandom_range(1, B / 2 - 5);
        rx = 1'b0;
        repeat (glitch) @(negedge sys_clk);
        rx = 1'b1;
        repeat (12 * B) @(negedge sys_clk);
        check("glitch_no_pulse", rxq.size(), 0);
        send_frame(8'h66, 1'b0, 1'b1, e0);
        expect_word("after_glitch", e0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, e0);
        send_frame(8'hFF, 1'b0, 1'b1, e1);
        expect_word("b2b_first", e0);
        expect_word("b2b_second", e1);

        // Reset in the middle of data bit 4.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (B / 2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midreset_data_out", data_out, 0);
        check("midreset_data_valid", data_valid, 0);
        check("midreset_parity_err", parity_err, 0);
        check("midreset_frame_err", frame_err, 0);
        rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12 * B) @(negedge sys_clk);
        check("midreset_no_pulse", rxq.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1, e0);
        expect_word("after_reset", e0);

        for (int n = 0; n < 16; n++) begin
            rd   = DW'($urandom);
            flip = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            stop = ($urandom_range(0, 3) != 0);
            send_frame(rd, flip, stop, e0);
            if (!stop) drive_bit(1'b1);
            rx = 1'b1;
            repeat ($urandom_range(0, B)) @(negedge sys_clk);
            expect_word($sformatf("rand%0d", n), e0);
        end

        repeat (2 * B) @(negedge sys_clk);
        check("pulse_width_one_cycle", width_viol, 0);
        check("total_pulses", pulses, expected_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
